multicycle_alu: RTL and testbench

- Registered, handshaked N-bit ALU; successor to the combinational Nbit_ALU.
- Adds AND, logical shifts, an iterative unsigned multiply, status flags and valid/ready flow control on input and output.
- Sits between an operand-issuing controller and a result consumer.
- Holds one operation at a time.

---
 rtl/alu_pkg.sv | 18 +
 rtl/shift_add_mul.sv | 60 ++++++
 rtl/multicycle_alu.sv | 159 +++++++++++++++
 tb/tb_multicycle_alu.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for multicycle_alu and its iterative multiplier:
// opcode values and FSM state constants.
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_OR  = 3'b010;
   localparam logic [2:0] OP_XOR = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_BUSY = 2'b01;
   localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/shift_add_mul.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle for N cycles.
// product is valid during the single cycle that done is high.
module shift_add_mul
   import alu_pkg::*;
#(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N-1:0]   A,
   input  logic [N-1:0]   B,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] product
);

   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   logic [2*N-1:0] r_mcand;
   logic [N-1:0]   r_mplier;
   logic [2*N-1:0] r_acc;
   logic [CW-1:0]  r_count;
   logic           r_busy;
   logic [2*N-1:0] w_accNext;

   // The final partial product is folded in combinationally so the caller
   // can capture the full product on the same edge the last step retires.
   assign w_accNext = r_acc + (r_mplier[0] ? r_mcand : '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy   <= 1'b0;
         r_count  <= '0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
      end else if (r_busy) begin
         r_acc    <= w_accNext;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_count  <= r_count + 1'b1;
         if (r_count == LAST) begin
            r_busy <= 1'b0;
         end
      end else if (start) begin
         r_acc    <= '0;
         r_mcand  <= {{N{1'b0}}, A};
         r_mplier <= B;
         r_count  <= '0;
         r_busy   <= 1'b1;
      end
   end

   assign busy    = r_busy;
   assign done    = r_busy && (r_count == LAST);
   assign product = w_accNext;

endmodule

// File: rtl/multicycle_alu.sv
// Registered, valid/ready handshaked N-bit ALU with an iterative multiplier.
// Define MULTICYCLE_ALU_SAT_EN to make ADD/SUB saturate unsigned instead of wrapping.
module multicycle_alu
   import alu_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic [2:0]   opcode,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] result,
   output logic [N-1:0] result_hi,
   output logic         carry,
   output logic         zero,
   output logic         overflow
);

`ifdef MULTICYCLE_ALU_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif
   localparam int LW = $clog2(N);

   logic [1:0]     r_state;
   logic [N-1:0]   r_result;
   logic [N-1:0]   r_resultHi;
   logic           r_carry;
   logic           r_zero;
   logic           r_overflow;

   logic           w_accept;
   logic           w_mulStart;
   logic           w_mulBusy;
   logic           w_mulDone;
   logic [2*N-1:0] w_product;
   logic [N:0]     w_sum;
   logic [N:0]     w_diff;
   logic [N:0]     w_shl;
   logic [N:0]     w_shr;
   logic           w_shBig;
   logic [N-1:0]   w_res;
   logic           w_carry;
   logic           w_ovf;

   assign in_ready   = (r_state == ST_IDLE) && !w_mulBusy && !rst;
   assign w_accept   = in_valid && in_ready;
   assign w_mulStart = w_accept && (opcode == OP_MUL);

   shift_add_mul #(.N(N)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (w_mulStart),
      .A       (A),
      .B       (B),
      .busy    (w_mulBusy),
      .done    (w_mulDone),
      .product (w_product)
   );

   // Single-cycle ops are evaluated straight from the inputs and captured at the accept edge.
   // The extra bit on each shift holds the last bit shifted out.
   always_comb begin
      w_sum   = {1'b0, A} + {1'b0, B};
      w_diff  = {1'b0, A} - {1'b0, B};
      w_shl   = {1'b0, A} << B[LW-1:0];
      w_shr   = {A, 1'b0} >> B[LW-1:0];
      w_shBig = |B[N-1:LW];
      w_res   = '0;
      w_carry = 1'b0;
      w_ovf   = 1'b0;
      case (opcode)
         OP_ADD: begin
            w_res   = (SAT_EN && w_sum[N]) ? '1 : w_sum[N-1:0];
            w_carry = w_sum[N];
            w_ovf   = (A[N-1] == B[N-1]) && (w_sum[N-1] != A[N-1]);
         end
         OP_SUB: begin
            w_res   = (SAT_EN && w_diff[N]) ? '0 : w_diff[N-1:0];
            w_carry = w_diff[N];
            w_ovf   = (A[N-1] != B[N-1]) && (w_diff[N-1] != A[N-1]);
         end
         OP_OR:  w_res = A | B;
         OP_XOR: w_res = A ^ B;
         OP_AND: w_res = A & B;
         OP_SHL: begin
            if (!w_shBig) begin
               w_res   = w_shl[N-1:0];
               w_carry = w_shl[N];
            end
         end
         OP_SHR: begin
            if (!w_shBig) begin
               w_res   = w_shr[N:1];
               w_carry = w_shr[0];
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_result   <= '0;
         r_resultHi <= '0;
         r_carry    <= 1'b0;
         r_zero     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  if (opcode == OP_MUL) begin
                     r_state <= ST_BUSY;
                  end else begin
                     r_state    <= ST_DONE;
                     r_result   <= w_res;
                     r_resultHi <= '0;
                     r_carry    <= w_carry;
                     r_overflow <= w_ovf;
                     r_zero     <= (w_res == '0);
                  end
               end
            end
            ST_BUSY: begin
               if (w_mulDone) begin
                  r_state    <= ST_DONE;
                  r_result   <= w_product[N-1:0];
                  r_resultHi <= w_product[2*N-1:N];
                  r_carry    <= |w_product[2*N-1:N];
                  r_overflow <= 1'b0;
                  r_zero     <= (w_product == '0);
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign out_valid = (r_state == ST_DONE);
   assign result    = r_result;
   assign result_hi = r_resultHi;
   assign carry     = r_carry;
   assign zero      = r_zero;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu: the driver pushes model results at each accept,
// an independent monitor pops and compares whenever the DUT presents a result.
module tb_multicycle_alu;

   localparam int N = 8;
   localparam longint M = longint'(1) << N;

`ifdef MULTICYCLE_ALU_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   typedef struct {
      logic [N-1:0] res;
      logic [N-1:0] hi;
      logic         c;
      logic         z;
      logic         v;
      int           lat;
      int           acc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [N-1:0] A = '0;
   logic [N-1:0] B = '0;
   logic [2:0]   opcode = 3'b000;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [N-1:0] result;
   logic [N-1:0] result_hi;
   logic         carry;
   logic         zero;
   logic         overflow;

   exp_t scoreQ[$];
   exp_t monE;
   int   cyc = 0;
   int   compared = 0;
   int   mismatched = 0;
   int   readyMode = 1;
   int   idleReq = 0;
   int   idleSeen = 0;
   int   busyReq = 0;
   int   busySeen = 0;
   bit   prevValid = 1'b0;
   bit   checkReadyNext = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   multicycle_alu #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .opcode    (opcode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .result_hi (result_hi),
      .carry     (carry),
      .zero      (zero),
      .overflow  (overflow)
   );

   // Consumer side: hold low, hold high or toggle randomly
   always @(posedge clk) begin
      #1;
      case (readyMode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   function automatic longint sgn(input longint x);
      return (x >= M / 2) ? x - M : x;
   endfunction

   // Reference model from the arithmetic rules, using wide integers
   function automatic exp_t model(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
      exp_t   e;
      longint ua, ub, full, sr;
      ua = longint'(a);
      ub = longint'(b);
      e.res = '0; e.hi = '0; e.c = 1'b0; e.v = 1'b0; e.lat = 1; e.acc = 0;
      case (op)
         3'd0: begin
            full  = ua + ub;
            e.c   = (full >= M);
            e.res = N'(full % M);
            sr    = sgn(ua) + sgn(ub);
            e.v   = (sr >= M / 2) || (sr < -(M / 2));
            if (SAT_EN && e.c) e.res = '1;
         end
         3'd1: begin
            full  = ua - ub;
            e.c   = (ua < ub);
            e.res = N'((full + M) % M);
            sr    = sgn(ua) - sgn(ub);
            e.v   = (sr >= M / 2) || (sr < -(M / 2));
            if (SAT_EN && e.c) e.res = '0;
         end
         3'd2: e.res = a | b;
         3'd3: e.res = a ^ b;
         3'd4: e.res = a & b;
         3'd5: begin
            if (ub == 0) e.res = a;
            else if (ub < N) begin
               e.res = N'((ua << ub) % M);
               e.c   = ((ua >> (N - ub)) & 1) != 0;
            end
         end
         3'd6: begin
            if (ub == 0) e.res = a;
            else if (ub < N) begin
               e.res = N'(ua >> ub);
               e.c   = ((ua >> (ub - 1)) & 1) != 0;
            end
         end
         default: begin
            full  = ua * ub;
            e.res = N'(full % M);
            e.hi  = N'(full / M);
            e.c   = (e.hi != 0);
            e.lat = N + 1;
         end
      endcase
      e.z = (e.res == 0) && (e.hi == 0);
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Present one operation, wait for the accept, and record its expected response
   task automatic applyStimulus(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
      exp_t e;
      int   waited;
      waited = 0;
      @(posedge clk);
      #1;
      opcode   = op;
      A        = a;
      B        = b;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready) begin
         waited++;
         if (waited > 200) begin
            $display("[TB] FAIL accept_timeout: in_ready stuck at 0, expected 1");
            $fatal(1, "[TB] no accept");
         end
         @(negedge clk);
      end
      e     = model(op, a, b);
      e.acc = cyc + 1;
      scoreQ.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      A        = N'($urandom);
      B        = N'($urandom);
      opcode   = 3'($urandom);
   endtask

   task automatic drain();
      int waited;
      waited = 0;
      while (scoreQ.size() != 0) begin
         @(negedge clk);
         waited++;
         if (waited > 1000) begin
            $display("[TB] FAIL drain_timeout: %0d results outstanding, expected 0", scoreQ.size());
            $fatal(1, "[TB] results never delivered");
         end
      end
      repeat (2) @(posedge clk);
   endtask

   // Monitor: all comparisons happen here, half a cycle away from the active edge
   always @(negedge clk) begin
      if (rst) begin
         scoreQ.delete();
         prevValid      = 1'b0;
         checkReadyNext = 1'b0;
         checkOutput("in_ready_during_reset", in_ready, 0);
         checkOutput("out_valid_during_reset", out_valid, 0);
      end else begin
         if (idleReq != idleSeen) begin
            idleSeen = idleReq;
            checkOutput("post_reset_out_valid", out_valid, 0);
            checkOutput("post_reset_result", result, 0);
            checkOutput("post_reset_result_hi", result_hi, 0);
            checkOutput("post_reset_carry", carry, 0);
            checkOutput("post_reset_zero", zero, 0);
            checkOutput("post_reset_overflow", overflow, 0);
            checkOutput("post_reset_in_ready", in_ready, 1);
         end
         if (busyReq != busySeen) begin
            busySeen = busyReq;
            checkOutput("busy_in_ready", in_ready, 0);
            checkOutput("busy_out_valid", out_valid, 0);
         end
         if (checkReadyNext) begin
            checkReadyNext = 1'b0;
            checkOutput("in_ready_after_done", in_ready, 1);
         end
         if (out_valid) begin
            if (scoreQ.size() == 0) begin
               checkOutput("unexpected_out_valid", out_valid, 0);
            end else begin
               monE = scoreQ[0];
               if (!prevValid) checkOutput("latency", 64'(cyc - monE.acc + 1), 64'(monE.lat));
               checkOutput("result", result, monE.res);
               checkOutput("result_hi", result_hi, monE.hi);
               checkOutput("carry", carry, monE.c);
               checkOutput("zero", zero, monE.z);
               checkOutput("overflow", overflow, monE.v);
               checkOutput("in_ready_while_done", in_ready, 0);
               if (out_ready) begin
                  void'(scoreQ.pop_front());
                  checkReadyNext = 1'b1;
               end
            end
         end
         prevValid = out_valid && !out_ready;
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [2:0]   op;
      logic [N-1:0] a, b;

      // Reset with a request pending: nothing may be accepted
      rst      = 1'b1;
      in_valid = 1'b1;
      opcode   = 3'b000;
      A        = 8'h01;
      B        = 8'h01;
      repeat (3) @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      idleReq++;

      $display("[TB] directed arithmetic, shift and multiply cases");
      applyStimulus(3'b000, 8'hF0, 8'h20);
      applyStimulus(3'b001, 8'h80, 8'h01);
      applyStimulus(3'b001, 8'h05, 8'h05);
      applyStimulus(3'b000, 8'h7F, 8'h01);
      applyStimulus(3'b111, 8'hFF, 8'hFF);
      for (int i = 0; i < N - 1; i++) begin
         busyReq++;
         in_valid = (i % 2 == 0);
         opcode   = 3'b000;
         A        = N'($urandom);
         B        = N'($urandom);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      applyStimulus(3'b101, 8'h81, 8'd1);
      applyStimulus(3'b110, 8'h81, 8'd1);
      applyStimulus(3'b101, 8'h81, 8'd8);
      applyStimulus(3'b110, 8'h81, 8'd0);
      applyStimulus(3'b111, 8'h00, 8'h37);
      drain();

      $display("[TB] backpressure on XOR");
      readyMode = 0;
      applyStimulus(3'b011, 8'hAA, 8'hFF);
      repeat (5) @(posedge clk);
      readyMode = 1;
      drain();

      $display("[TB] reset in the middle of a multiply");
      applyStimulus(3'b111, 8'hC3, 8'h5A);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      idleReq++;
      applyStimulus(3'b000, 8'h01, 8'h01);
      drain();

      $display("[TB] randomized operations with random out_ready");
      readyMode = 2;
      for (int i = 0; i < 80; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
         if (op == 3'd5 || op == 3'd6) b = N'($urandom_range(0, N + 2));
         else b = N'($urandom);
         applyStimulus(op, a, b);
      end
      drain();
      readyMode = 1;
      repeat (3) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
